// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and byte-enable helper for the MEM-stage data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    be_mask = 4'b0001 << lo;
      SZ_H:    be_mask = lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be_mask = 4'b1111;
      default: be_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering: byte enables, replicated store data,
// load extraction with sign/zero extension, and the misalign/illegal-size flag.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = i_lo[1] ? i_rword[31:16] : i_rword[15:0];
  assign w_byte = i_lo[0] ? w_half[15:8] : w_half[7:0];

  always_comb begin
    o_be       = be_mask(i_size, i_lo);
    o_wdata    = i_wdata;
    o_rdata    = '0;
    o_misalign = 1'b0;
    case (i_size)
      SZ_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_misalign = i_lo[0];
      end
      SZ_W: begin
        o_rdata    = i_rword;
        o_misalign = |i_lo;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request, WAIT_CYCLES wait states, registered
// response; array is read/written on the edge that enters RESP.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 32,
  parameter int          ADDR_W      = 32,
  parameter int          WAIT_CYCLES = 0,
  parameter int          INIT_IDX    = 12,
  parameter logic [31:0] INIT_VAL    = 32'h0000_001E
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam state_t ACC_STATE = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_we, r_uns;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept, w_latched, w_access;
  logic              w_we, w_uns, w_oor, w_misalign, w_err;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata, w_wsh, w_ext;
  logic [3:0]        w_be;
  logic [IDX_W-1:0]  w_idx;

  assign req_ready  = !rst && (r_state == ST_IDLE || r_state == ST_RESP);
  assign w_accept   = req_valid && req_ready;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // With zero wait states the access happens on the accept edge itself, so use live inputs.
  assign w_latched = (r_state == ST_WAIT);
  assign w_we      = w_latched ? r_we    : req_we;
  assign w_size    = w_latched ? r_size  : req_size;
  assign w_uns     = w_latched ? r_uns   : req_unsigned;
  assign w_addr    = w_latched ? r_addr  : req_addr;
  assign w_wdata   = w_latched ? r_wdata : req_wdata;

  assign w_idx = w_addr[IDX_W+1:2];
  assign w_oor = (w_addr >> 2) >= ADDR_W'(DEPTH);
  assign w_err = w_oor || w_misalign;

  dmem_align u_align (
    .i_size     (w_size),
    .i_lo       (w_addr[1:0]),
    .i_unsigned (w_uns),
    .i_wdata    (w_wdata),
    .i_rword    (r_mem[w_idx]),
    .o_be       (w_be),
    .o_wdata    (w_wsh),
    .o_rdata    (w_ext),
    .o_misalign (w_misalign)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RESP: w_next = w_accept ? ACC_STATE : ST_IDLE;
      ST_WAIT:          if (r_cnt <= 4'd1) w_next = ST_RESP;
      default:          w_next = ST_IDLE;
    endcase
  end

  assign w_access = !rst && (w_next == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= 4'(WAIT_CYCLES);
      else if (r_state == ST_WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= (i == INIT_IDX) ? INIT_VAL : 32'h0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_err   <= w_err;
      r_rdata <= (w_we || w_err) ? 32'h0 : w_ext;
      if (w_we && !w_err) begin
        for (int b = 0; b < 4; b++)
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
      end
    end
  end

endmodule
